// File: rtl/cpack_dict_ctrl.sv
// cpack_dict_ctrl: Stage1 compressor sequencer and dictionary owner.
// Takes one word at a time, presents it to the external comparator with the
// current dictionary, registers the match result as a code record and, once
// the record is taken, applies the FIFO-replacement dictionary update.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds its payload stable until that transfer.
// in_ready_o does not depend on in_valid_i, and out_valid_o does not depend
// on out_ready_i.
module cpack_dict_ctrl #(
  parameter int WIDTH = 32,
  parameter int WORDS = 16,
  localparam int IW = $clog2(WORDS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH-1:0]       in_word_i,
  output logic [WORDS*WIDTH-1:0] dict_o,
  output logic [WORDS-1:0]       dict_valid_o,
  output logic [WIDTH-1:0]       cmp_word_o,
  input  logic [2:0]             cmp_class_i,
  input  logic [IW-1:0]          cmp_idx_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [2:0]             out_class_o,
  output logic [IW-1:0]          out_idx_o,
  output logic [WIDTH-1:0]       out_word_o,
  output logic [IW:0]            dict_fill_o,
  output logic                   busy_o,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam logic [IW:0] FILL_MAX = (IW+1)'(WORDS);

  state_t             state_q;
  logic [WIDTH-1:0]   dict_q [WORDS];
  logic [IW-1:0]      wr_ptr_q;
  logic               flush_pend_q;
  logic               upd_class;

  // Only literal-carrying classes (xxxx, mmxx, mmmx) teach the dictionary a new word.
  assign upd_class = (out_class_o == 3'd1) || (out_class_o == 3'd3) ||
                     (out_class_o == 3'd5);

  assign in_ready_o  = (state_q == IDLE) && !flush_i && !flush_pend_q;
  assign out_valid_o = (state_q == EMIT);
  assign busy_o      = (state_q != IDLE) || flush_pend_q;
  assign dbg_state_o = state_q;

  // Flatten the dictionary for the comparator: entry k at [k*WIDTH +: WIDTH].
  for (genvar k = 0; k < WORDS; k++) begin : g_flat
    assign dict_o[k*WIDTH +: WIDTH] = dict_q[k];
  end

  // Sequencer FSM plus dictionary, pointer, fill and record registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      for (int k = 0; k < WORDS; k++) dict_q[k] <= '0;
      dict_valid_o <= '0;
      wr_ptr_q     <= '0;
      dict_fill_o  <= '0;
      cmp_word_o   <= '0;
      out_class_o  <= '0;
      out_idx_o    <= '0;
      out_word_o   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A flush (fresh or deferred) takes the whole IDLE cycle; no word accepted.
          if (flush_i || flush_pend_q) begin
            for (int k = 0; k < WORDS; k++) dict_q[k] <= '0;
            dict_valid_o <= '0;
            wr_ptr_q     <= '0;
            dict_fill_o  <= '0;
            flush_pend_q <= 1'b0;
          end else if (in_valid_i) begin
            cmp_word_o <= in_word_i;
            state_q    <= CMP;
          end
        end
        CMP: begin
          // Illegal classes 6/7 degrade to a plain literal (xxxx).
          out_class_o <= (cmp_class_i > 3'd5) ? 3'd1 : cmp_class_i;
          out_idx_o   <= cmp_idx_i;
          out_word_o  <= cmp_word_o;
          state_q     <= EMIT;
          if (flush_i) flush_pend_q <= 1'b1;
        end
        EMIT: begin
          if (flush_i) flush_pend_q <= 1'b1;
          if (out_ready_i) begin
            if (upd_class) begin
              dict_q[wr_ptr_q]       <= out_word_o;
              dict_valid_o[wr_ptr_q] <= 1'b1;
              wr_ptr_q               <= wr_ptr_q + 1'b1;
              if (dict_fill_o != FILL_MAX) dict_fill_o <= dict_fill_o + 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpack_dict_ctrl.sv
// Bench for cpack_dict_ctrl: directed scenarios plus randomized words, checked
// against a dictionary model built from "n-th written word lands in slot n mod 16".
module tb_cpack_dict_ctrl;

  localparam int W = 32;
  localparam int N = 16;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  in_word_i;
  logic [N*W-1:0] dict_o;
  logic [N-1:0]  dict_valid_o;
  logic [W-1:0]  cmp_word_o;
  logic [2:0]    cmp_class_i;
  logic [3:0]    cmp_idx_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [2:0]    out_class_o;
  logic [3:0]    out_idx_o;
  logic [W-1:0]  out_word_o;
  logic [4:0]    dict_fill_o;
  logic          busy_o;
  logic [1:0]    dbg_state_o;

  cpack_dict_ctrl #(.WIDTH(W), .WORDS(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_word_i(in_word_i),
    .dict_o(dict_o), .dict_valid_o(dict_valid_o), .cmp_word_o(cmp_word_o),
    .cmp_class_i(cmp_class_i), .cmp_idx_i(cmp_idx_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_class_o(out_class_o), .out_idx_o(out_idx_o), .out_word_o(out_word_o),
    .dict_fill_o(dict_fill_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [38:0] exp_q[$];       // {class, idx, word} of records yet to appear
  logic [W-1:0] model_dict[N];
  int model_writes = 0;        // words written since last flush/reset

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_fill();
    return (model_writes > N) ? N : model_writes;
  endfunction

  function automatic logic [N-1:0] model_valid();
    logic [N-1:0] v = '0;
    for (int i = 0; i < model_fill(); i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_clear();
    model_writes = 0;
    for (int i = 0; i < N; i++) model_dict[i] = '0;
  endtask

  task automatic check_dict(input string tag);
    chk({tag, "_fill"}, dict_fill_o, model_fill());
    chk({tag, "_valid"}, dict_valid_o, model_valid());
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_entry%0d", tag, k), dict_o[k*W +: W], model_dict[k]);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge. Sends one word, plays the comparator, optionally
  // stalls the output and optionally pulses flush_i during CMP.
  task automatic send(input logic [W-1:0] w, input logic [2:0] cls, input logic [3:0] idx,
                      input int stall, input bit flush_cmp);
    int guard = 0;
    logic [2:0] ecls;
    logic [38:0] exp_rec;
    while (in_ready_o !== 1'b1 && guard < 10) begin
      @(negedge clk_i);
      guard++;
    end
    chk("in_ready", in_ready_o, 1);
    if (in_ready_o === 1'b1) begin
      in_valid_i  = 1'b1;
      in_word_i   = w;
      cmp_class_i = cls;
      cmp_idx_i   = idx;
      ecls = (cls > 3'd5) ? 3'd1 : cls;
      exp_q.push_back({ecls, idx, w});
      @(negedge clk_i);                       // CMP cycle
      in_valid_i = 1'b0;
      in_word_i  = $urandom;
      chk("cmp_word", cmp_word_o, w);
      chk("cmp_no_valid", out_valid_o, 0);
      chk("cmp_in_ready", in_ready_o, 0);
      check_dict("cmp");
      if (flush_cmp) flush_i = 1'b1;
      @(negedge clk_i);                       // first EMIT cycle, 2 after accept
      flush_i     = 1'b0;
      cmp_class_i = 3'($urandom);
      cmp_idx_i   = 4'($urandom);
      exp_rec = exp_q.pop_front();
      chk("emit_valid", out_valid_o, 1);
      chk("emit_rec", {out_class_o, out_idx_o, out_word_o}, exp_rec);
      chk("emit_in_ready", in_ready_o, 0);
      chk("emit_busy", busy_o, 1);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk_i);
        chk("hold_valid", out_valid_o, 1);
        chk("hold_rec", {out_class_o, out_idx_o, out_word_o}, exp_rec);
        chk("hold_in_ready", in_ready_o, 0);
        check_dict("hold");
      end
      out_ready_i = 1'b1;
      @(negedge clk_i);
      out_ready_i = 1'b0;
      if (ecls == 3'd1 || ecls == 3'd3 || ecls == 3'd5) begin
        model_dict[model_writes % N] = w;
        model_writes++;
      end
      chk("post_valid", out_valid_o, 0);
      check_dict("post");
      if (flush_cmp) begin
        chk("pend_in_ready", in_ready_o, 0);
        chk("pend_busy", busy_o, 1);
        model_clear();
        @(negedge clk_i);
        check_dict("flushed");
        chk("flushed_in_ready", in_ready_o, 1);
        chk("flushed_busy", busy_o, 0);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0; in_valid_i = 1'b0; in_word_i = '0;
    cmp_class_i = '0; cmp_idx_i = '0; out_ready_i = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // T1 reset state
    chk("t1_in_ready", in_ready_o, 1);
    chk("t1_out_valid", out_valid_o, 0);
    chk("t1_busy", busy_o, 0);
    chk("t1_rec", {out_class_o, out_idx_o, out_word_o}, 0);
    chk("t1_cmp_word", cmp_word_o, 0);
    check_dict("t1");

    // T2 two literal words
    send(32'h11223344, 3'd1, 4'd0, 0, 0);
    send(32'h55667788, 3'd1, 4'd3, 0, 0);
    chk("t2_entry1", dict_o[1*W +: W], 32'h55667788);

    // T3 zzzx leaves the dictionary alone; 6/7 degrade to xxxx and write
    send(32'h0000000A, 3'd4, 4'd1, 0, 0);
    chk("t3_fill", dict_fill_o, 2);
    send(32'hDEADBEEF, 3'd6, 4'd2, 0, 0);
    send(32'hCAFEF00D, 3'd7, 4'd5, 0, 0);
    send(32'h12340000, 3'd0, 4'd7, 0, 0);
    send(32'h12345678, 3'd2, 4'd9, 0, 0);
    send(32'h12345600, 3'd3, 4'd9, 0, 0);
    send(32'h123456AB, 3'd5, 4'd9, 0, 0);

    // Flush in IDLE with a word offered: nothing accepted, dictionary cleared
    flush_i = 1'b1; in_valid_i = 1'b1; in_word_i = 32'hFFFF0000;
    #1 chk("iflush_in_ready", in_ready_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0; in_valid_i = 1'b0;
    model_clear();
    chk("iflush_out_valid", out_valid_o, 0);
    chk("iflush_busy", busy_o, 0);
    chk("iflush_cmp_word", cmp_word_o, 32'h123456AB);
    check_dict("iflush");

    // T4 17 literals wrap the pointer, fill saturates
    for (int i = 0; i <= 16; i++) send(32'(i), 3'd1, 4'(i), 0, 0);
    chk("t4_fill", dict_fill_o, 16);
    chk("t4_entry0", dict_o[0 +: W], 32'd16);
    chk("t4_entry1", dict_o[W +: W], 32'd1);

    // T5 back-pressure for 5 cycles
    send(32'hA5A5A5A5, 3'd3, 4'd4, 5, 0);

    // Randomized traffic
    for (int i = 0; i < 30; i++)
      send($urandom, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 3), 0);

    // T6 flush during CMP with a literal
    send(32'h0BADCAFE, 3'd1, 4'd0, 1, 1);
    send(32'h00C0FFEE, 3'd1, 4'd0, 0, 0);

    // Reset mid-record: in-flight word dropped, everything cleared
    in_valid_i = 1'b1; in_word_i = 32'h77777777; cmp_class_i = 3'd1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("mid_out_valid", out_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    model_clear();
    exp_q.delete();
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cmp_word", cmp_word_o, 0);
    check_dict("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    send(32'h31415926, 3'd5, 4'd2, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
